// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: a Moore FSM that sequences fetch/decode/execute
// per opcode and counts completed instruction fetches.
module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCondEQ,
  output logic                   PCWriteCondNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic                   IllegalOp,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  state_t                 r_state;
  logic [5:0]             r_op;
  logic [COUNT_WIDTH-1:0] r_count;
  state_t                 w_state;
  logic                   w_op_legal;

  assign InstrCount = r_count;

  always_comb begin
    case (OP)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: w_op_legal = 1'b1;
      default: w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_op    <= 6'h00;
      r_count <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (MemReady) begin
          r_state <= S_DECODE;
          r_count <= r_count + COUNT_WIDTH'(1);
        end
        S_DECODE: begin
          r_op <= OP;
          case (OP)
            OP_RTYPE:        r_state <= S_EXEC_R;
            OP_ADDI, OP_ORI: r_state <= S_EXEC_I;
            OP_LW, OP_SW:    r_state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:  r_state <= S_BRANCH;
            OP_J:            r_state <= S_JUMP;
            default:         r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: r_state <= (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (MemReady) r_state <= S_MEM_WB;
        S_MEM_WR:   if (MemReady) r_state <= S_FETCH;
        S_EXEC_R:   r_state <= S_R_WB;
        S_EXEC_I:   r_state <= S_I_WB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // While reset is held low the outputs show FETCH values with every strobe
  // suppressed, regardless of where the state register currently sits.
  assign w_state = reset ? r_state : S_FETCH;

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    PCSource      = 2'b00;
    IllegalOp     = 1'b0;
    case (w_state)
      S_FETCH: begin
        MemRead = reset;
        IRWrite = reset & MemReady;
        PCWrite = reset & MemReady;
        ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = ~w_op_legal;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (r_op == OP_ORI) ? 3'b101 : 3'b100;
      end
      S_I_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b001;
        PCSource      = 2'b01;
        PCWriteCondEQ = (r_op == OP_BEQ);
        PCWriteCondNE = (r_op == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port OP  input  6  opcode field from the instruction register.
REQ-005 SHALL have port MemReady  input  1  memory access complete this cycle.
REQ-006 SHALL have port PCWrite  output  1  unconditional PC load.
REQ-007 SHALL have port PCWriteCondEQ  output  1  PC load if ALU zero=1.
REQ-008 SHALL have port PCWriteCondNE  output  1  PC load if ALU zero=0.
REQ-009 SHALL have port IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 SHALL have port MemRead  output  1  memory read strobe.
REQ-011 SHALL have port MemWrite  output  1  memory write strobe.
REQ-012 SHALL have port IRWrite  output  1  instruction register load.
REQ-013 SHALL have port MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR.
REQ-014 SHALL have port RegDst  output  1  destination register: 0=rt, 1=rd.
REQ-015 SHALL have port RegWrite  output  1  register file write strobe.
REQ-016 SHALL have port ALUSrcA  output  1  ALU A operand: 0=PC, 1=regA.
REQ-017 SHALL have port ALUSrcB  output  2  ALU B operand: 00=regB, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-018 SHALL have port ALUOp  output  3  000=add, 001=sub, 100=ADDI, 101=ORI, 111=R-type funct.
REQ-019 SHALL have port PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-020 SHALL have port IllegalOp  output  1  unsupported opcode flag.
REQ-021 SHALL have port InstrCount  output  COUNT_WIDTH  count of completed instruction fetches.

Function
REQ-022 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP; every output not listed for a state SHALL be 0.
REQ-023 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=MemReady; remain while MemReady=0, go to DECODE when MemReady=1.
REQ-024 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000; SHALL latch OP into an internal opcode register; next state by OP: 0x00->EXEC_R, 0x08/0x0D->EXEC_I, 0x23/0x2B->MEM_ADDR, 0x04/0x05->BRANCH, 0x02->JUMP, any other->FETCH.
REQ-025 DECODE with unsupported OP SHALL assert IllegalOp for exactly that one cycle and issue no write strobe.
REQ-026 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next MEM_RD if latched op=0x23, else MEM_WR.
REQ-027 MEM_RD: MemRead=1, IorD=1; hold until MemReady=1, then MEM_WB. MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-028 MEM_WR: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
REQ-029 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next R_WB. R_WB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-030 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=100 for 0x08, 101 for 0x0D; next I_WB. I_WB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWriteCondEQ=1 for 0x04, PCWriteCondNE=1 for 0x05; next FETCH.
REQ-032 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-033 Cycle counts SHALL be, with MemReady=1 on first request: R/ADDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J 3, illegal 2.
REQ-034 InstrCount SHALL increment by 1 on each edge where state=FETCH and MemReady=1, wrapping from 2^COUNT_WIDTH-1 to 0.
REQ-035 OP changes outside DECODE SHALL have no effect; MemReady outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-036 When reset=0 at a rising clk edge, the block SHALL enter FETCH and clear InstrCount and the latched opcode to 0, from any state including mid-wait.
REQ-037 While reset=0, PCWrite, PCWriteCondEQ, PCWriteCondNE, IRWrite, MemRead, MemWrite, RegWrite and IllegalOp SHALL be forced 0; all other outputs SHALL take FETCH values.

Verification
REQ-038 reset=0 two cycles, then 1, MemReady=1, OP=0x00 -> FETCH,DECODE,EXEC_R(ALUOp=111),R_WB(RegWrite=1,RegDst=1); InstrCount=1.
REQ-039 OP=0x23, MemReady=0 for 3 cycles in MEM_RD -> MemRead=1, IorD=1 held 4 cycles, then MEM_WB with MemtoReg=1, RegWrite=1.
REQ-040 OP=0x05 -> BRANCH cycle with PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=001, PCSource=01.
REQ-041 OP=0x3F -> IllegalOp=1 one cycle in DECODE, no strobes, FETCH next; InstrCount counts fetch only.
REQ-042 OP=0x2B, reset=0 while in MEM_WR with MemReady=0 -> MemWrite=0 that cycle, FETCH next edge, InstrCount=0.
REQ-043 COUNT_WIDTH=4, 16 J instructions -> InstrCount wraps 15->0.
